// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte FIFO sitting between the MMIO UART TX outputs
// and the UART core. Firmware bursts bytes in; the drain FSM hands them to the
// UART core one frame at a time and reports level/full/empty/overflow status.
//
// Handshake summary:
// - Write side: a push is accepted on a clk edge with wr_en=1, full=0 and
//   flush=0. Here full acts as !ready. It is taken from the registered count,
//   so a pop in the same cycle never makes room for a push.
// - UART side: uart_tx_ena is a one-cycle launch. It is issued only from IDLE,
//   and only on an edge where uart_tx_busy was sampled low.
// - The launch counts as consumed when uart_tx_busy rises. If busy does not
//   rise within BUSY_WAIT cycles, the launch is treated as accepted and is
//   not retried.
module uart_tx_fifo #(
    parameter int DEPTH_BITS = 4,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  overflow_clr,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   level,
    output logic                  overflow,
    output logic                  idle,
    output logic                  uart_tx_ena,
    output logic [7:0]            uart_tx_data,
    input  logic                  uart_tx_busy
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int TW    = $clog2(BUSY_WAIT) + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic                  r_tx_ena;
    logic [7:0]            r_tx_data;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

    assign w_full  = (r_count == (DEPTH_BITS + 1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // A flush discards any push in the same cycle, and that push does not count as dropped.
    assign w_push = wr_en && !w_full && !flush;
    assign w_drop = wr_en &&  w_full && !flush;

    // Launching from IDLE is the only way a byte leaves the array.
    assign w_pop  = (r_state == S_IDLE) && !w_empty && !uart_tx_busy && !flush;

    // Byte storage: written on accepted pushes only, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy count; flush empties the queue but not the in-flight byte.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_BITS + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_BITS + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a dropped push wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Drain FSM: launch one byte, then wait for the UART core to take it and finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_tx_ena  <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_tx_ena <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_tx_ena  <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == TW'(BUSY_WAIT - 1)) begin
                        // The core never signalled busy; assume the launch was taken.
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign level        = r_count;
    assign overflow     = r_overflow;
    assign idle         = (r_state == S_IDLE) && w_empty;
    assign uart_tx_ena  = r_tx_ena;
    assign uart_tx_data = r_tx_data;

endmodule
